// File: rtl/pwm_decode.sv
// ---------------------------------------------------------------------------
// pwm_decode
//
// Recovers the speed magnitude and direction of one motor channel from its
// forward/reverse PWM pin pair, and flags forward/reverse shoot-through.
//
// Parameters
//   PERIOD     clocks per PWM period (2048 for the 11-bit generator)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   PWM_frwrd  forward PWM pin
//   PWM_rev    reverse PWM pin
//   clr_flt    clears the sticky shoot-through fault
//   spd[10:0]  high time of the last complete period, in clocks (max 2047)
//   rev        direction of the last measured period, 1 = reverse
//   vld        one-cycle pulse, spd/rev updated this cycle
//   flt        sticky shoot-through fault (both pins high together)
//
// Optional build macro
//   PWM_DECODE_SYNC_EN  when defined, each pin passes through a 2-flop
//                       synchronizer ahead of the input register (+2 clocks
//                       latency, measured values unchanged). When undefined,
//                       the pins must already be synchronous to clk.
// ---------------------------------------------------------------------------
module pwm_decode #(
  parameter int PERIOD = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PWM_frwrd,
  input  logic        PWM_rev,
  input  logic        clr_flt,
  output logic [10:0] spd,
  output logic        rev,
  output logic        vld,
  output logic        flt
);

  localparam int CW = $clog2(2 * PERIOD);
  // Widen to at least 11 bits so the 2047 clamp is well formed for any PERIOD.
  localparam int HW = (CW > 11) ? CW : 11;

  localparam logic [CW-1:0] TMO_CNT = CW'(2 * PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [10:0]   SPD_MAX = 11'd2047;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Input stage
  // -------------------------------------------------------------------------
  logic [1:0] pin_s;   // {rev, frwrd} as presented to the input register

`ifdef PWM_DECODE_SYNC_EN
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
    end else begin
      meta_reg <= {PWM_rev, PWM_frwrd};
      sync_reg <= meta_reg;
    end
  end

  assign pin_s = sync_reg;
`else
  assign pin_s = {PWM_rev, PWM_frwrd};
`endif

  logic f_q;
  logic r_q;
  logic pwm;
  logic pwm_d;
  logic rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 1'b0;
      r_q   <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      f_q   <= pin_s[0];
      r_q   <= pin_s[1];
      pwm_d <= pwm;
    end
  end

  // Either pin high counts as "on"; direction is tracked separately.
  assign pwm  = f_q | r_q;
  assign rise = pwm & ~pwm_d;

  // -------------------------------------------------------------------------
  // FSM: state register / next-state logic / control decode
  // -------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  logic [CW-1:0] per_cnt_reg;
  logic [CW-1:0] hi_cnt_reg;

  logic meas_upd;   // period closed by a rising edge
  logic tmo_upd;    // period closed by timeout (no edge for 2*PERIOD-1)

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = MEAS;
      MEAS:    state_next = MEAS;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    meas_upd = 1'b0;
    tmo_upd  = 1'b0;
    if (state_reg == MEAS) begin
      // A rising edge in the timeout cycle takes priority.
      if (rise) begin
        meas_upd = 1'b1;
      end else if (per_cnt_reg == TMO_CNT) begin
        tmo_upd = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Period / high-time counters (saturating)
  // -------------------------------------------------------------------------
  // On an edge both reload to 1: the edge cycle itself is the first high
  // cycle of the new period. After a timeout they restart from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else if (rise) begin
      per_cnt_reg <= CW'(1);
      hi_cnt_reg  <= CW'(1);
    end else if (tmo_upd) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else begin
      if (per_cnt_reg != CNT_MAX) begin
        per_cnt_reg <= per_cnt_reg + CW'(1);
      end
      if (pwm && (hi_cnt_reg != CNT_MAX)) begin
        hi_cnt_reg <= hi_cnt_reg + CW'(1);
      end
    end
  end

  // Direction of the most recent high cycle. Sampled before the edge cycle
  // updates it, so at an edge it still describes the period just closed.
  logic dir_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_reg <= 1'b0;
    end else if (pwm) begin
      dir_reg <= r_q;
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  logic [HW-1:0] hi_w;
  logic [10:0]   spd_sat;

  assign hi_w    = HW'(hi_cnt_reg);
  assign spd_sat = (hi_w > HW'(SPD_MAX)) ? SPD_MAX : hi_w[10:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      spd <= 11'd0;
      rev <= 1'b0;
      vld <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (meas_upd) begin
        spd <= spd_sat;
        rev <= dir_reg;
        vld <= 1'b1;
      end else if (tmo_upd) begin
        // Stuck high reads as full scale, stuck low as zero; direction only
        // meaningful while the pin is actually driven.
        spd <= pwm ? SPD_MAX : 11'd0;
        if (pwm) begin
          rev <= dir_reg;
        end
        vld <= 1'b1;
      end
    end
  end

  // Sticky shoot-through fault; a new overlap beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt <= 1'b0;
    end else if (f_q & r_q) begin
      flt <= 1'b1;
    end else if (clr_flt) begin
      flt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// ---------------------------------------------------------------------------
// tb_pwm_decode
//
// Drives pin waveforms one clock at a time from a stimulus process. A
// reference model built on the decoder's observable rules (window of high
// cycles since the last edge or timeout, 4095/4096-cycle timeout spacing,
// sticky fault) pushes expected {time, spd, rev} into a scoreboard queue. A
// separate monitor pops and compares whenever vld is seen, flags missing or
// extra pulses, and checks flt every cycle.
// ---------------------------------------------------------------------------
module tb_pwm_decode;

  logic        clk;
  logic        rst;
  logic        PWM_frwrd;
  logic        PWM_rev;
  logic        clr_flt;
  logic [10:0] spd;
  logic        rev;
  logic        vld;
  logic        flt;

  pwm_decode #(.PERIOD(2048)) dut (
    .clk       (clk),
    .rst       (rst),
    .PWM_frwrd (PWM_frwrd),
    .PWM_rev   (PWM_rev),
    .clr_flt   (clr_flt),
    .spd       (spd),
    .rev       (rev),
    .vld       (vld),
    .flt       (flt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [10:0] spd;
    logic        rev;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int errs     = 0;
  int zero_chk = -1;
  bit mon_on   = 1'b1;

  // Reference model state
  bit armed     = 1'b0;
  bit prev_p    = 1'b0;
  bit last_dir  = 1'b0;
  bit held_rev  = 1'b0;
  bit ov_prev   = 1'b0;
  bit flt_exp   = 1'b0;
  int win_start = 0;
  int highs     = 0;

  // k = posedge count at the negedge where the pins are driven. The pins
  // become visible to the decoder in cycle k+1 and a result lands at k+2.
  task automatic model_step(input bit f, input bit r, input bit c,
                            input bit rs, input int k);
    bit   p;
    bit   rise;
    int   dc;
    exp_t e;
    // Fault update at edge k+1 uses the overlap seen in cycle k.
    if (rs)           flt_exp = 1'b0;
    else if (ov_prev) flt_exp = 1'b1;
    else if (c)       flt_exp = 1'b0;
    ov_prev = rs ? 1'b0 : (f & r);

    if (rs) begin
      armed    = 1'b0;
      prev_p   = 1'b0;
      last_dir = 1'b0;
      held_rev = 1'b0;
      sb.delete();
      zero_chk = k + 1;
      return;
    end

    dc   = k + 1;
    p    = f | r;
    rise = p & ~prev_p;
    if (!armed) begin
      if (rise) begin
        armed     = 1'b1;
        win_start = dc;
        highs     = 1;
      end
    end else if (rise) begin
      e.t   = dc + 1;
      e.spd = (highs > 2047) ? 11'd2047 : 11'(highs);
      e.rev = last_dir;
      sb.push_back(e);
      held_rev  = last_dir;
      win_start = dc;
      highs     = 1;
    end else if (dc - win_start == 4095) begin
      e.t   = dc + 1;
      e.spd = p ? 11'd2047 : 11'd0;
      e.rev = p ? last_dir : held_rev;
      sb.push_back(e);
      held_rev  = e.rev;
      win_start = dc + 1;
      highs     = 0;
    end else begin
      highs = highs + int'(p);
    end
    if (p) last_dir = r;
    prev_p = p;
  endtask

  task automatic step(input bit f, input bit r, input bit c, input bit rs);
    @(negedge clk);
    PWM_frwrd = f;
    PWM_rev   = r;
    clr_flt   = c;
    rst       = rs;
    model_step(f, r, c, rs, cyc);
  endtask

  // One generator period: high for d clocks on the selected pin, then low.
  task automatic period(input int d, input int per, input bit rv);
    for (int i = 0; i < per; i++) begin
      step((i < d) && !rv, (i < d) && rv, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard checker
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        checks++;
        if (flt !== flt_exp) begin
          errs++;
          $display("FAIL flt t=%0d got %0b want %0b", cyc, flt, flt_exp);
        end
        if (cyc == zero_chk) begin
          checks++;
          if ({spd, rev, vld} !== 13'd0) begin
            errs++;
            $display("FAIL reset_zero t=%0d got spd=%0d rev=%0b vld=%0b want all 0",
                     cyc, spd, rev, vld);
          end
        end
        while (sb.size() > 0 && sb[0].t < cyc) begin
          checks++;
          errs++;
          e = sb.pop_front();
          $display("FAIL missing_vld got none want vld at t=%0d spd=%0d rev=%0b",
                   e.t, e.spd, e.rev);
        end
        if (vld === 1'b1) begin
          checks++;
          if (sb.size() == 0 || sb[0].t != cyc) begin
            errs++;
            $display("FAIL spurious_vld t=%0d got vld spd=%0d rev=%0b want no vld",
                     cyc, spd, rev);
          end else begin
            e = sb.pop_front();
            $display("vld t=%0d spd=%0d rev=%0b", cyc, spd, rev);
            if (spd !== e.spd || rev !== e.rev) begin
              errs++;
              $display("FAIL result t=%0d got spd=%0d rev=%0b want spd=%0d rev=%0b",
                       cyc, spd, rev, e.spd, e.rev);
            end
          end
        end else if (vld !== 1'b0) begin
          checks++;
          errs++;
          $display("FAIL vld_unknown t=%0d got %b want 0/1", cyc, vld);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int per;
    int d;
    bit rv;
    rst       = 1'b1;
    PWM_frwrd = 1'b0;
    PWM_rev   = 1'b0;
    clr_flt   = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Forward, duty 1024
    for (int i = 0; i < 3; i++) period(1024, 2048, 1'b0);
    // Reverse 300, then forward 1500
    for (int i = 0; i < 2; i++) period(300, 2048, 1'b1);
    for (int i = 0; i < 2; i++) period(1500, 2048, 1'b0);
    // Duty extremes
    period(1, 2048, 1'b0);
    period(2047, 2048, 1'b0);
    // Edge landing exactly in the timeout cycle
    period(100, 4095, 1'b0);
    // Reverse periods then pins held low: repeated timeouts
    for (int i = 0; i < 2; i++) period(300, 2048, 1'b1);
    idle(8400);
    // Constant high
    for (int i = 0; i < 4300; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    // Shoot-through: set, clear coinciding with overlap, clear alone
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // Reset in the middle of a period, then re-arm and measure
    for (int i = 0; i < 700; i++) step(i < 400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) period(1000, 2048, 1'b0);

    // Randomized periods and duties
    for (int i = 0; i < 12; i++) begin
      per = ($urandom_range(0, 1) == 1) ? 2048 : int'($urandom_range(2, 4200));
      d   = int'($urandom_range(1, per - 1));
      rv  = 1'($urandom_range(0, 1));
      period(d, per, rv);
    end
    idle(10);

    @(negedge clk);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
